// File: rtl/serial_word_transmitter_pkg.sv
// Shared definitions for serial_word_transmitter: state encoding, default word width
// and counter sizing. The PARITY state exists only with SERIAL_WORD_TRANSMITTER_PARITY_EN.
package serial_word_transmitter_pkg;

    localparam int DEFAULT_WIDTH = 8;

`ifdef SERIAL_WORD_TRANSMITTER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;
`endif

    // A one-bit counter is still needed for a two-bit word.
    function automatic int counter_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_word_transmitter_bit_counter.sv
// Bit position counter for serial_word_transmitter: synchronous clear beats count-enable,
// terminal flags the last data bit of a frame.
module bit_counter
    import serial_word_transmitter_pkg::*;
#(
    parameter int LAST = DEFAULT_WIDTH - 1,
    parameter int CW   = counter_width(LAST + 1)
)
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CW-1:0] LAST_COUNT = CW'(LAST);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST_COUNT);

endmodule

// File: rtl/serial_word_transmitter.sv
// MSB-first serializer feeding a downstream left-shift register through out/out_enable.
// Define SERIAL_WORD_TRANSMITTER_PARITY_EN to append an even-parity bit to every frame.
module serial_word_transmitter
    import serial_word_transmitter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             hold,
    output logic             out,
    output logic             out_enable,
    output logic             busy,
    output logic             done
);

    localparam int CW = counter_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shift_word;
    logic             last_bit;
    logic             bit_step;
    logic             frame_end;
    logic             accept;
    logic             counter_clear;
`ifdef SERIAL_WORD_TRANSMITTER_PARITY_EN
    logic             parity_bit;
`endif

    assign bit_step = (state == ST_SHIFT) && !hold;

`ifdef SERIAL_WORD_TRANSMITTER_PARITY_EN
    assign frame_end  = (state == ST_PARITY) && !hold;
    assign out        = (state == ST_PARITY) ? parity_bit
                                             : ((state == ST_SHIFT) && shift_word[WIDTH-1]);
    assign out_enable = bit_step || frame_end;
`else
    assign frame_end  = bit_step && last_bit;
    assign out        = (state == ST_SHIFT) && shift_word[WIDTH-1];
    assign out_enable = bit_step;
`endif

    // Ready at the frame's final bit as well as in IDLE, so frames can run back to back.
    assign busy          = (state != ST_IDLE);
    assign done          = frame_end;
    assign load_ready    = !reset && ((state == ST_IDLE) || frame_end);
    assign accept        = load_valid && load_ready;
    assign counter_clear = accept || (bit_step && last_bit);

    bit_counter #(
        .LAST (WIDTH - 1),
        .CW   (CW)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (counter_clear),
        .enable   (bit_step),
        .terminal (last_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift_word <= '0;
`ifdef SERIAL_WORD_TRANSMITTER_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (accept) begin
            state      <= ST_SHIFT;
            shift_word <= data_in;
`ifdef SERIAL_WORD_TRANSMITTER_PARITY_EN
            parity_bit <= ^data_in;
`endif
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (!hold) begin
                        shift_word <= shift_word << 1;
                        if (last_bit) begin
`ifdef SERIAL_WORD_TRANSMITTER_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef SERIAL_WORD_TRANSMITTER_PARITY_EN
                ST_PARITY: begin
                    if (!hold) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Self-checking bench for serial_word_transmitter: a queue-of-bits frame model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic with resets.
module tb_serial_word_transmitter;

    localparam int WIDTH = 8;
`ifdef SERIAL_WORD_TRANSMITTER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
    localparam logic [FRAME-1:0] D6_BITS = {8'hD6, 1'b1};
    localparam logic [WIDTH-1:0] D6_WORD = 8'hAD;
`else
    localparam int FRAME = WIDTH;
    localparam logic [FRAME-1:0] D6_BITS = 8'hD6;
    localparam logic [WIDTH-1:0] D6_WORD = 8'hD6;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             load_valid;
    logic             hold;
    logic [WIDTH-1:0] data_in;
    logic             load_ready;
    logic             out;
    logic             out_enable;
    logic             busy;
    logic             done;

    int tests    = 0;
    int failures = 0;

    logic [WIDTH-1:0] ds       = '0;
    logic [WIDTH-1:0] ds_model = '0;
    bit               exp_q[$];

    serial_word_transmitter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .hold       (hold),
        .out        (out),
        .out_enable (out_enable),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Downstream left-shift register driven by the serial link.
    always @(posedge clk) begin
        if (out_enable) ds <= {ds[WIDTH-2:0], out};
    end

    function automatic logic frameBit(input logic [WIDTH-1:0] w, input int i);
        if (i < WIDTH) return w[WIDTH-1-i];
        return ^w;
    endfunction

    function automatic logic [WIDTH-1:0] expectedWord(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < FRAME; i++) r = {r[WIDTH-2:0], frameBit(w, i)};
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Frame model: the pending bits of the frame in flight; one leaves per unheld cycle.
    always @(posedge clk or posedge reset) begin : model
        logic busy_m;
        logic ready_m;
        if (reset) begin
            exp_q.delete();
        end else begin
            busy_m  = (exp_q.size() != 0);
            ready_m = !busy_m || (!hold && exp_q.size() == 1);
            if (busy_m && !hold) ds_model = {ds_model[WIDTH-2:0], exp_q.pop_front()};
            if (ready_m && load_valid)
                for (int i = 0; i < FRAME; i++) exp_q.push_back(frameBit(data_in, i));
        end
    end

    always @(negedge clk) begin : compare
        logic b_m;
        logic last_m;
        b_m    = (exp_q.size() != 0);
        last_m = b_m && !hold && (exp_q.size() == 1);
        checkOutput("busy", WIDTH'(busy), WIDTH'(b_m));
        checkOutput("out", WIDTH'(out), WIDTH'(b_m ? exp_q[0] : 1'b0));
        checkOutput("out_enable", WIDTH'(out_enable), WIDTH'(b_m && !hold));
        checkOutput("done", WIDTH'(done), WIDTH'(last_m));
        checkOutput("load_ready", WIDTH'(load_ready), WIDTH'(!reset && (!b_m || last_m)));
        checkOutput("downstream", ds, ds_model);
    end

    task automatic applyStimulus(input logic lv, input logic [WIDTH-1:0] d, input logic h);
        @(posedge clk);
        #1;
        load_valid = lv;
        data_in    = d;
        hold       = h;
        #2;
    endtask

    initial begin
        int enabled;
        int held;
        int cycles;
        reset      = 1'b0;
        load_valid = 1'b0;
        hold       = 1'b0;
        data_in    = '0;
        #1 reset   = 1'b1;

        applyStimulus(1'b1, 8'h77, 1'b0);
        checkOutput("reset_ready", WIDTH'(load_ready), '0);
        checkOutput("reset_busy", WIDTH'(busy), '0);
        checkOutput("reset_oe", WIDTH'(out_enable), '0);
        applyStimulus(1'b0, '0, 1'b0);
        reset = 1'b0;
        #1 checkOutput("ready_after_reset", WIDTH'(load_ready), WIDTH'(1'b1));

        // Single D6 frame with literal bit pattern.
        applyStimulus(1'b1, 8'hD6, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b0, '0, 1'b0);
            checkOutput("d6_bit", WIDTH'(out), WIDTH'(D6_BITS[FRAME-1-i]));
            checkOutput("d6_oe", WIDTH'(out_enable), WIDTH'(1'b1));
            checkOutput("d6_done", WIDTH'(done), WIDTH'(i == FRAME - 1));
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("d6_word", ds, D6_WORD);
        checkOutput("d6_idle", WIDTH'(busy), '0);

        // Back-to-back A5 then 3C with load_valid held.
        applyStimulus(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            applyStimulus(i < FRAME, 8'h3C, 1'b0);
            checkOutput("b2b_oe", WIDTH'(out_enable), WIDTH'(1'b1));
            checkOutput("b2b_done", WIDTH'(done), WIDTH'(i == FRAME - 1 || i == 2 * FRAME - 1));
            checkOutput("b2b_bit", WIDTH'(out),
                        WIDTH'(frameBit((i < FRAME) ? 8'hA5 : 8'h3C, i % FRAME)));
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("b2b_word", ds, expectedWord(8'h3C));

        // D6 with three hold cycles after the third bit.
        applyStimulus(1'b1, 8'hD6, 1'b0);
        enabled = 0;
        held    = 0;
        cycles  = 0;
        while (enabled < FRAME && cycles < 30) begin
            cycles++;
            if (enabled == 3 && held < 3) begin
                applyStimulus(1'b0, '0, 1'b1);
                held++;
                checkOutput("hold_out", WIDTH'(out), WIDTH'(1'b1));
                checkOutput("hold_oe", WIDTH'(out_enable), '0);
            end else begin
                applyStimulus(1'b0, '0, 1'b0);
                if (out_enable) enabled++;
            end
        end
        checkOutput("hold_len", WIDTH'(enabled), WIDTH'(FRAME));
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("hold_word", ds, D6_WORD);

        // load_valid pulse with 00 mid-frame must be ignored.
        applyStimulus(1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < FRAME; i++) applyStimulus(i == 3, 8'h00, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("ignore_word", ds, expectedWord(8'h5A));
        checkOutput("ignore_idle", WIDTH'(busy), '0);

        // Reset after the fourth bit of FF, then a clean 01 frame.
        applyStimulus(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("pre_reset_oe", WIDTH'(out_enable), WIDTH'(1'b1));
        reset = 1'b1;
        #1;
        checkOutput("async_out", WIDTH'(out), '0);
        checkOutput("async_oe", WIDTH'(out_enable), '0);
        checkOutput("async_ready", WIDTH'(load_ready), '0);
        applyStimulus(1'b0, '0, 1'b0);
        reset = 1'b0;
        #1 checkOutput("post_reset_ready", WIDTH'(load_ready), WIDTH'(1'b1));
        applyStimulus(1'b1, 8'h01, 1'b0);
        for (int i = 0; i < FRAME; i++) applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("after_reset_word", ds, expectedWord(8'h01));

        // Randomized traffic with holds and occasional asynchronous resets.
        for (int c = 0; c < 1500; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom),
                          $urandom_range(0, 3) == 0);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 99) == 0) reset = 1'b1;
        end
        applyStimulus(1'b0, '0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < FRAME + 2; i++) applyStimulus(1'b0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
